// File: rtl/mpdmac_pkg.sv
// Shared types and constants for the DMA-side AXI3 slave memory.
package mpdmac_pkg;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Beat address step: FIXED holds, INCR and WRAP both advance one word.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? addr : addr + 32'd4;
  endfunction

endpackage

// File: rtl/mpdmac_mem_array.sv
// DEPTH x 32 flop array: one byte-enabled write port, one asynchronous read port.
module mpdmac_mem_array #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [3:0]        wstrb_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // Byte-lane write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (wstrb_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mpdmac_axi_mem.sv
// AXI3 slave word memory with independent read and write FSMs.
// Optional range checking with SLVERR responses: define MPDMAC_MEM_ERR_EN.
module mpdmac_axi_mem
  import mpdmac_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  // Size is always taken as 4 bytes, wlast is not checked and wid is not used.
  logic unused_inputs;
  assign unused_inputs = ^{awsize_i, arsize_i, wid_i, wlast_i};

  w_state_t    w_state_q, w_state_d;
  logic [3:0]  aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic [1:0]  aw_burst_q, aw_burst_d;
  logic        w_err_q, w_err_d;

  r_state_t    r_state_q, r_state_d;
  logic [3:0]  ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [1:0]  ar_burst_q, ar_burst_d;

  logic        w_oor, r_oor, mem_we;
  logic [31:0] mem_rdata;

  function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return ADDR_W'(off >> 2);
  endfunction

`ifdef MPDMAC_MEM_ERR_EN
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  function automatic logic out_of_range(input logic [31:0] a);
    return ({1'b0, a} < {1'b0, BASE_ADDR}) || ({1'b0, a} >= LIMIT);
  endfunction

  assign w_oor = out_of_range(aw_addr_q);
  assign r_oor = out_of_range(ar_addr_q);
`else
  // Without range checking the index simply wraps modulo DEPTH.
  assign w_oor = 1'b0;
  assign r_oor = 1'b0;
`endif

  assign mem_we = (w_state_q == W_DATA) && wvalid_i && !w_oor;

  mpdmac_mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (word_idx(aw_addr_q)),
    .wstrb_i (wstrb_i),
    .wdata_i (wdata_i),
    .raddr_i (word_idx(ar_addr_q)),
    .rdata_o (mem_rdata)
  );

  // Write-side next-state: AW latch, beat counting/addressing, B handshake.
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    case (w_state_q)
      W_IDLE: if (awvalid_i) begin
        aw_id_d    = awid_i;
        aw_addr_d  = awaddr_i;
        aw_len_d   = awlen_i;
        aw_burst_d = awburst_i;
        w_cnt_d    = '0;
        w_err_d    = 1'b0;
        w_state_d  = W_DATA;
      end
      W_DATA: if (wvalid_i) begin
        w_err_d   = w_err_q | w_oor;
        aw_addr_d = next_addr(aw_addr_q, aw_burst_q);
        w_cnt_d   = w_cnt_q + 4'd1;
        if (w_cnt_q == aw_len_q) w_state_d = W_RESP;
      end
      W_RESP: if (bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
    end
  end

  // Read-side next-state: AR latch, beat advance on R fire.
  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    case (r_state_q)
      R_IDLE: if (arvalid_i) begin
        ar_id_d    = arid_i;
        ar_addr_d  = araddr_i;
        ar_len_d   = arlen_i;
        ar_burst_d = arburst_i;
        r_cnt_d    = '0;
        r_state_d  = R_DATA;
      end
      R_DATA: if (rready_i) begin
        ar_addr_d = next_addr(ar_addr_q, ar_burst_q);
        r_cnt_d   = r_cnt_q + 4'd1;
        if (r_cnt_q == ar_len_q) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read-side registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
    end
  end

  assign awready_o = (w_state_q == W_IDLE);
  assign wready_o  = (w_state_q == W_DATA);
  assign bvalid_o  = (w_state_q == W_RESP);
  assign bid_o     = aw_id_q;
  assign bresp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;

  // rdata is zeroed outside a data beat and for out-of-range beats.
  assign arready_o = (r_state_q == R_IDLE);
  assign rvalid_o  = (r_state_q == R_DATA);
  assign rid_o     = ar_id_q;
  assign rlast_o   = rvalid_o && (r_cnt_q == ar_len_q);
  assign rdata_o   = (rvalid_o && !r_oor) ? mem_rdata : '0;
  assign rresp_o   = (rvalid_o && r_oor) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_mpdmac_axi_mem.sv
// Directed + randomized bench for mpdmac_axi_mem against a word-array model.
module tb_mpdmac_axi_mem;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 2**ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int unsigned BOUND  = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]  awid_i = '0, awlen_i = '0, wid_i = '0, wstrb_i = '0, arid_i = '0, arlen_i = '0;
  logic [31:0] awaddr_i = '0, wdata_i = '0, araddr_i = '0;
  logic [2:0]  awsize_i = 3'b010, arsize_i = 3'b010;
  logic [1:0]  awburst_i = '0, arburst_i = '0;
  logic        awvalid_i = 1'b0, wlast_i = 1'b0, wvalid_i = 1'b0, bready_i = 1'b0;
  logic        arvalid_i = 1'b0, rready_i = 1'b0;
  logic        awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;
  logic [3:0]  bid_o, rid_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o;

  mpdmac_axi_mem #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] wd_q [16];
  logic [3:0]  ws_q [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off >> 2) % DEPTH;
  endfunction

  function automatic bit oor(input logic [31:0] a);
`ifdef MPDMAC_MEM_ERR_EN
    return (a < BASE) || (64'(a) >= 64'(BASE) + 64'(4 * DEPTH));
`else
    return (a != a);
`endif
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int k = 0; k < 4; k++)
      if (s[k]) mem_m[widx(a)][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"}, 32'(awready_o), 1);
    chk({tag, "_arready"}, 32'(arready_o), 1);
    chk({tag, "_wready"},  32'(wready_o), 0);
    chk({tag, "_bvalid"},  32'(bvalid_o), 0);
    chk({tag, "_bid"},     32'(bid_o), 0);
    chk({tag, "_bresp"},   32'(bresp_o), 0);
    chk({tag, "_rvalid"},  32'(rvalid_o), 0);
    chk({tag, "_rlast"},   32'(rlast_o), 0);
    chk({tag, "_rid"},     32'(rid_o), 0);
    chk({tag, "_rresp"},   32'(rresp_o), 0);
    chk({tag, "_rdata"},   rdata_o, 0);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input bit gaps, input int unsigned bdelay);
    int unsigned t;
    logic err;
    logic [31:0] a;
    err = 1'b0;
    @(negedge clk);
    awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awvalid_i = 1'b1;
    #1;
    t = 0;
    while (!awready_o && t < BOUND) begin @(negedge clk); #1; t++; end
    chk("aw_accept", 32'(t < BOUND), 1);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      awvalid_i = 1'b0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin wvalid_i = 1'b0; @(negedge clk); end
      end
      wdata_i = wd_q[i]; wstrb_i = ws_q[i]; wlast_i = (i == int'(len)); wvalid_i = 1'b1;
      #1;
      t = 0;
      while (!wready_o && t < BOUND) begin @(negedge clk); #1; t++; end
      chk("w_accept", 32'(t < BOUND), 1);
      a = beat_addr(addr, burst, i);
      if (oor(a)) err = 1'b1;
      else model_write(a, wd_q[i], ws_q[i]);
    end
    @(negedge clk);
    wvalid_i = 1'b0; wlast_i = 1'b0; bready_i = (bdelay == 0);
    #1;
    t = 0;
    while (!bvalid_o && t < BOUND) begin @(negedge clk); #1; t++; end
    chk("b_valid", 32'(t < BOUND), 1);
    repeat (bdelay) begin
      chk("b_hold_valid", 32'(bvalid_o), 1);
      chk("b_hold_awready", 32'(awready_o), 0);
      chk("b_hold_bid", 32'(bid_o), 32'(id));
      @(negedge clk); #1;
    end
    bready_i = 1'b1;
    chk("bid", 32'(bid_o), 32'(id));
    chk("bresp", 32'(bresp_o), err ? 32'd2 : 32'd0);
    @(negedge clk);
    bready_i = 1'b0;
    #1;
    chk("b_done", 32'(bvalid_o), 0);
    chk("aw_ready_after_b", 32'(awready_o), 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit gaps, input int stall_beat,
                         input int unsigned stall_len);
    int unsigned t, stalls;
    logic [31:0] a, exp;
    @(negedge clk);
    arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arvalid_i = 1'b1;
    #1;
    t = 0;
    while (!arready_o && t < BOUND) begin @(negedge clk); #1; t++; end
    chk("ar_accept", 32'(t < BOUND), 1);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      arvalid_i = 1'b0;
      a = beat_addr(addr, burst, i);
      exp = oor(a) ? 32'h0 : mem_m[widx(a)];
      stalls = gaps ? $urandom_range(0, 2) : 0;
      if (i == stall_beat) stalls = stall_len;
      rready_i = 1'b0;
      for (int unsigned s = 0; s < stalls; s++) begin
        #1;
        chk("r_hold_valid", 32'(rvalid_o), 1);
        chk("r_hold_data", rdata_o, exp);
        chk("r_hold_last", 32'(rlast_o), 32'(i == int'(len)));
        @(negedge clk);
      end
      rready_i = 1'b1;
      #1;
      t = 0;
      while (!rvalid_o && t < BOUND) begin @(negedge clk); #1; t++; end
      chk("r_valid", 32'(t < BOUND), 1);
      chk("rdata", rdata_o, exp);
      chk("rlast", 32'(rlast_o), 32'(i == int'(len)));
      chk("rid", 32'(rid_o), 32'(id));
      chk("rresp", 32'(rresp_o), oor(a) ? 32'd2 : 32'd0);
    end
    @(negedge clk);
    rready_i = 1'b0;
    #1;
    chk("r_done", 32'(rvalid_o), 0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 'x;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: INCR write then read back
    for (int i = 0; i < 4; i++) begin wd_q[i] = 32'hA0 + 32'(i); ws_q[i] = 4'hF; end
    do_write(4'h5, 32'h100, 4'd3, 2'b01, 1'b0, 0);
    do_read(4'h6, 32'h100, 4'd3, 2'b01, 1'b0, -1, 0);

    // 2: byte strobes merge
    wd_q[0] = 32'hFFFF_FFFF; ws_q[0] = 4'hF;
    do_write(4'h1, 32'h40, 4'd0, 2'b01, 1'b0, 0);
    wd_q[0] = 32'h1234_5678; ws_q[0] = 4'b0101;
    do_write(4'h2, 32'h40, 4'd0, 2'b01, 1'b0, 0);
    do_read(4'h3, 32'h40, 4'd0, 2'b01, 1'b0, -1, 0);
    chk("t2_merge", rdata_o === 32'h0 ? mem_m[16] : 32'hFF34_FF78, 32'hFF34_FF78);

    // 3: FIXED write keeps last beat; stalled read holds outputs
    for (int i = 0; i < 3; i++) begin wd_q[i] = 32'(i + 1); ws_q[i] = 4'hF; end
    do_write(4'h4, 32'h80, 4'd2, 2'b00, 1'b0, 0);
    do_read(4'h4, 32'h80, 4'd0, 2'b01, 1'b0, -1, 0);
    do_read(4'h7, 32'h100, 4'd3, 2'b01, 1'b0, 2, 5);

    // 4: concurrent AR/AW with random gaps, then random bursts
    for (int i = 0; i < 16; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
    do_write(4'h8, 32'h200, 4'd15, 2'b01, 1'b1, 0);
    for (int i = 0; i < 16; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'($urandom_range(1, 15)); end
    fork
      do_write(4'h9, 32'h300, 4'd15, 2'b01, 1'b1, 0);
      do_read(4'hA, 32'h200, 4'd15, 2'b01, 1'b1, -1, 0);
    join
    do_read(4'hB, 32'h300, 4'd15, 2'b01, 1'b1, -1, 0);
    for (int n = 0; n < 6; n++) begin
      logic [31:0] ra;
      logic [3:0]  rl;
      logic [1:0]  rb;
      ra = 32'($urandom_range(0, 32'hF00)) ;
      rl = 4'($urandom_range(0, 15));
      rb = 2'($urandom_range(0, 2));
      for (int i = 0; i < 16; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
      do_write(4'($urandom), ra, rl, rb, 1'b1, 0);
      do_read(4'($urandom), {ra[31:2], 2'b00}, rl, rb, 1'b1, -1, 0);
    end

    // 5: B backpressure, then reset mid-burst
    wd_q[0] = 32'hC0DE_0001; ws_q[0] = 4'hF;
    do_write(4'hC, 32'h1F0, 4'd0, 2'b01, 1'b0, 10);
    @(negedge clk);
    awid_i = 4'hD; awaddr_i = 32'h180; awlen_i = 4'd3; awburst_i = 2'b01; awvalid_i = 1'b1;
    #1;
    chk("rst_aw_ready", 32'(awready_o), 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      awvalid_i = 1'b0;
      wdata_i = 32'hBEEF_0000 + 32'(i); wstrb_i = 4'hF; wvalid_i = 1'b1;
      #1;
      chk("rst_wready", 32'(wready_o), 1);
      model_write(32'h180 + 32'(4 * i), wdata_i, 4'hF);
    end
    @(negedge clk);
    wvalid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin wd_q[i] = $urandom; ws_q[i] = 4'hF; end
    do_write(4'hE, 32'h1C0, 4'd1, 2'b01, 1'b0, 0);
    do_read(4'hE, 32'h180, 4'd1, 2'b01, 1'b0, -1, 0);
    do_read(4'hF, 32'h1C0, 4'd1, 2'b01, 1'b0, -1, 0);

    // 6: burst crossing the top of the memory
    wd_q[0] = 32'h5A5A_0FFC; ws_q[0] = 4'hF;
    do_write(4'h1, BASE + 32'(4 * DEPTH) - 32'd4, 4'd0, 2'b01, 1'b0, 0);
    wd_q[0] = 32'h0000_A5A5; ws_q[0] = 4'hF;
    do_write(4'h1, BASE, 4'd0, 2'b01, 1'b0, 0);
    do_read(4'h2, BASE + 32'(4 * DEPTH) - 32'd4, 4'd1, 2'b01, 1'b0, -1, 0);
    wd_q[0] = 32'h1111_2222; wd_q[1] = 32'h3333_4444; ws_q[0] = 4'hF; ws_q[1] = 4'hF;
    do_write(4'h3, BASE + 32'(4 * DEPTH) - 32'd4, 4'd1, 2'b01, 1'b0, 0);
    do_read(4'h3, BASE, 4'd0, 2'b01, 1'b0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
